// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the arbitrated memory controller.
package mem_ctrl_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned AW_DEF  = 4;
    localparam int unsigned NCH_DEF = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM: synchronous write, registered read with enable.
module sp_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // Array write; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: loads only on a read, otherwise holds its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbitrated single-port memory with post-reset zero fill.
module mem_arb_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned NCH        = NCH_DEF,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    rvalid,
    output logic [DW-1:0]     rdata,
    output logic              ready
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          gany;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    assign ready = (state == RUN);

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        gnt  = '0;
        gidx = ptr;
        gany = 1'b0;
        if (state == RUN) begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                idx = (32'(ptr) + k) % NCH;
                if (!gany && req[idx]) begin
                    gany     = 1'b1;
                    gidx     = PW'(idx);
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    // RAM port owner: the clear counter in INIT, the granted channel in RUN.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == INIT) begin
            ram_en   = (INIT_CLEAR != 0);
            ram_we   = 1'b1;
            ram_addr = cnt;
        end else begin
            ram_en    = gany;
            ram_we    = we[gidx];
            ram_addr  = addr[gidx*AW +: AW];
            ram_wdata = wdata[gidx*DW +: DW];
        end
    end

    // INIT walks the counter across every address once, then hands over to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if ((INIT_CLEAR == 0) || (cnt == '1)) begin
                        state <= RUN;
                    end
                end
                RUN: state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // Pointer follows the granted channel; reset value lets channel 0 win first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= PW'(NCH - 1);
        end else if (gany) begin
            ptr <= gidx;
        end
    end

    // Read-return strobe lines up with the RAM's registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= '0;
        end else if (gany && !we[gidx]) begin
            rvalid <= gnt;
        end else begin
            rvalid <= '0;
        end
    end

    sp_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench for mem_arb_ctrl (DW=8, AW=4, NCH=2, INIT_CLEAR=1).
module tb_mem_arb_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr;
    logic [15:0] wdata;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata;
    logic       ready;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  gnt;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } sb_t;

    int         total;
    int         bad;
    bit         mon_on;
    logic [7:0] last_rd;
    logic [7:0] mm [16];
    sb_t        sb [$];
    sb_t        e;
    vec_t       tbl [14];

    mem_arb_ctrl #(
        .DW         (8),
        .AW         (4),
        .NCH        (2),
        .INIT_CLEAR (1)
    ) dut (
        .clk    (clk),
        .rst    (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every rvalid pulse must match the oldest predicted read.
    always @(negedge clk) begin
        if (mon_on && rst_n) begin
            if (rvalid !== 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rvalid_spurious", 32'(rvalid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_ch", 32'(rvalid), 32'(2'b01 << e.ch));
                    chk("rdata", 32'(rdata), 32'(e.data));
                    last_rd = e.data;
                end
            end else begin
                chk("rdata_hold", 32'(rdata), 32'(last_rd));
            end
        end
    end

    // One bus cycle: drive, check grant, then update model at the edge.
    task automatic cycle(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a,
                         input logic [15:0] d, input logic [1:0] eg, input string nm);
        int         ch;
        logic [3:0] ad;
        sb_t        it;
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        #2;
        chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
        @(posedge clk);
        if (eg != 2'b00) begin
            ch = eg[1] ? 1 : 0;
            ad = a[ch*4 +: 4];
            if (w[ch]) begin
                mm[ad] = d[ch*8 +: 8];
            end else begin
                it.ch   = ch;
                it.data = mm[ad];
                sb.push_back(it);
            end
        end
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        chk("init_ready_low", 32'(ready), 32'h0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n = c;
                break;
            end
            chk("init_gnt", 32'(gnt), 32'h0);
        end
        for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        mon_on  = 1'b1;
        last_rd = 8'h00;
        for (int i = 0; i < 16; i++) mm[i] = 8'hxx;

        tbl[0]  = '{2'b01, 2'b01, 8'h03, 16'h00A5, 2'b01};
        tbl[1]  = '{2'b01, 2'b00, 8'h03, 16'h0000, 2'b01};
        tbl[2]  = '{2'b10, 2'b10, 8'h10, 16'h3C00, 2'b10};
        tbl[3]  = '{2'b01, 2'b01, 8'h02, 16'h0077, 2'b01};
        tbl[4]  = '{2'b11, 2'b00, 8'h21, 16'h0000, 2'b10};
        tbl[5]  = '{2'b11, 2'b00, 8'h21, 16'h0000, 2'b01};
        tbl[6]  = '{2'b11, 2'b00, 8'h21, 16'h0000, 2'b10};
        tbl[7]  = '{2'b11, 2'b00, 8'h21, 16'h0000, 2'b01};
        tbl[8]  = '{2'b00, 2'b11, 8'h22, 16'hFFFF, 2'b00};
        tbl[9]  = '{2'b11, 2'b00, 8'h21, 16'h0000, 2'b10};
        tbl[10] = '{2'b10, 2'b00, 8'h30, 16'h0000, 2'b10};
        tbl[11] = '{2'b10, 2'b00, 8'h30, 16'h0000, 2'b10};
        tbl[12] = '{2'b01, 2'b01, 8'h04, 16'h005A, 2'b01};
        tbl[13] = '{2'b10, 2'b00, 8'h40, 16'h0000, 2'b10};

        // Reset with both channels already requesting.
        rst_n = 1'b0;
        req   = 2'b11;
        we    = 2'b00;
        addr  = 8'h21;
        wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        rst_n = 1'b1;

        wait_ready(n);
        chk("init_len", 32'(n), 32'd16);
        chk("first_run_gnt", 32'(gnt), 32'h1);

        // Whole memory reads back as zero after the fill.
        for (int i = 0; i < 16; i++) begin
            cycle(2'b01, 2'b00, {4'h0, 4'(i)}, 16'h0000, 2'b01, "zero_rd");
        end

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].gnt,
                  $sformatf("vec%0d", i));
        end

        // Reset lands right after a read is accepted: its return must vanish.
        req  = 2'b01;
        we   = 2'b00;
        addr = 8'h03;
        #2;
        chk("abort_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", 32'(rvalid), 32'h0);
        chk("abort_rdata", 32'(rdata), 32'h0);
        chk("abort_ready", 32'(ready), 32'h0);
        chk("abort_gnt_rst", 32'(gnt), 32'h0);
        req = 2'b00;
        repeat (3) @(posedge clk);
        last_rd = 8'h00;
        #1;
        rst_n = 1'b1;
        wait_ready(n);
        chk("reinit_len", 32'(n), 32'd16);

        cycle(2'b01, 2'b00, 8'h03, 16'h0000, 2'b01, "reinit_rd3");
        cycle(2'b01, 2'b00, 8'h01, 16'h0000, 2'b01, "reinit_rd1");
        req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 Parameter DW, default 8: data width in bits, 1..32.
REQ-002 Parameter AW, default 4: address width; DEPTH = 2**AW words.
REQ-003 Parameter NCH, default 2: requester channel count, 1..4.
REQ-004 Parameter INIT_CLEAR, default 1: 1 = zero-fill the memory after reset; 0 = no fill.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 req  input  NCH  per-channel access request, held until granted.
REQ-008 we  input  NCH  per-channel access type: 1 = write, 0 = read; qualified by req.
REQ-009 addr  input  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
REQ-010 wdata  input  NCH*DW  per-channel write data; channel i occupies bits [i*DW +: DW].
REQ-011 gnt  output  NCH  one-hot grant; an access is accepted on a rising edge where req[i] & gnt[i] = 1.
REQ-012 rvalid  output  NCH  one-hot, one-cycle pulse marking read data returned to channel i.
REQ-013 rdata  output  DW  read data, shared by all channels; qualified by rvalid.
REQ-014 ready  output  1  high when the block is in RUN.

Function
REQ-015 The block SHALL implement the states INIT and RUN.
REQ-016 INIT (INIT_CLEAR=1): a counter SHALL write 0 to addresses 0..DEPTH-1, one per cycle, then move to RUN; INIT therefore lasts DEPTH cycles.
REQ-017 With INIT_CLEAR=0, the block SHALL enter RUN on the first clock edge after reset release.
REQ-018 In INIT, gnt SHALL be 0 and ready SHALL be 0; requests SHALL be ignored, not queued.
REQ-019 In RUN, gnt SHALL be combinational from req and the round-robin pointer, and SHALL have at most one bit set.
REQ-020 Round-robin: search starts at channel (ptr+1) mod NCH; ptr SHALL update to the granted channel on each accepted access; ptr holds when there is no access.
REQ-021 Throughput SHALL be one access per cycle; back-to-back grants to the same channel are allowed when it is the only requester.
REQ-022 Write: on the accepting edge, wdata of the granted channel SHALL be stored at its addr; no rvalid pulse.
REQ-023 Read: rdata SHALL be valid and rvalid[i] SHALL pulse high exactly one cycle after the accepting edge; read latency is 1.
REQ-024 rdata SHALL hold its last value when rvalid = 0.
REQ-025 A write accepted in cycle N followed by a read of the same address in cycle N+1 SHALL return the new data.
REQ-026 Requests with req low SHALL NOT affect memory or ptr, whatever we, addr and wdata are.

Reset
REQ-027 While rst = 0, the outputs SHALL be gnt=0, rvalid=0, rdata=0, ready=0; ptr SHALL be NCH-1, so channel 0 wins first; the init counter SHALL be 0.
REQ-028 Reset asserted mid-INIT or mid-read SHALL abort immediately; a pending rvalid SHALL be discarded; INIT SHALL restart from address 0 after release.
REQ-029 Memory contents SHALL NOT be cleared by reset itself, only by INIT.

Structure
REQ-030 Package mem_ctrl_pkg SHALL hold the state enum (INIT, RUN) and the default values of DW, AW and NCH.
REQ-031 Storage SHALL be a sub-module sp_ram: DEPTH x DW, single port, synchronous write, registered read, so it maps to block RAM.
REQ-032 The arbiter, the init counter and the FSM SHALL reside in mem_arb_ctrl.

Verification (DW=8, AW=4, NCH=2)
REQ-033 Reset release with INIT_CLEAR=1 -> ready rises after 16 cycles; reading addresses 0..15 returns 0x00 for all.
REQ-034 ch0 writes 0xA5 to addr 3, then reads addr 3 the next cycle -> rvalid[0] pulses one cycle after acceptance with rdata=0xA5.
REQ-035 Both channels hold req continuously with reads of addr 1 and addr 2 -> grants alternate ch0, ch1, ch0, ...; rvalid alternates and carries the correct data for each channel.
REQ-036 Requests during INIT -> gnt stays 0; first grant occurs on the first RUN cycle.
REQ-037 rst asserted in the cycle after a read is accepted -> no rvalid pulse; after release, INIT restarts at address 0 and the previously written 0xA5 is zeroed.
